// File: rtl/mem_access_stage.sv
// Memory-access stage: req/ack dmem bus, sized/extended loads, byte-strobed stores; 1-cycle result for non-memory ops.
// stall_o holds execute for the whole bus access (ack cycle included); MEM_ACCESS_TIMEOUT_EN adds a bus watchdog.
module mem_access_stage #(
  parameter int XLEN           = 64,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            valid_i,
  input  logic            mem_read_i,
  input  logic            mem_write_i,
  input  logic            reg_write_i,
  input  logic [2:0]      funct3_i,
  input  logic [4:0]      rd_i,
  input  logic [XLEN-1:0] alu_result_i,
  input  logic [XLEN-1:0] wr_ram_data_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [7:0]      dmem_wstrb_o,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            valid_o,
  output logic            reg_write_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] mem_result_o,
  output logic            misalign_o,
  output logic            bus_err_o
);

  if (XLEN != 64 || TIMEOUT_CYCLES < 1) begin : g_cfg_check
    $error("mem_access_stage: XLEN must be 64 and TIMEOUT_CYCLES >= 1");
  end

  typedef enum logic {IDLE, WAIT} state_t;

  typedef struct packed {
    logic       is_store;
    logic       reg_write;
    logic [4:0] rd;
    logic [2:0] funct3;
    logic [2:0] off;
  } ctx_t;

  state_t      state_q, state_d;
  ctx_t        ctx_q;
  logic        is_mem;
  logic        aligned;
  logic [2:0]  off;
  logic [7:0]  st_wstrb;
  logic [63:0] st_wdata;
  logic [63:0] ld_shift;
  logic [63:0] ld_data;
  logic        tmo_expire;

  assign is_mem  = mem_read_i | mem_write_i;
  assign off     = alu_result_i[2:0];
  assign stall_o = (state_q == WAIT);

  // funct3[1:0] is the access size for both loads and stores
  always_comb begin
    aligned = 1'b1;
    case (funct3_i[1:0])
      2'b01:   aligned = ~off[0];
      2'b10:   aligned = (off[1:0] == 2'b00);
      2'b11:   aligned = (off == 3'b000);
      default: aligned = 1'b1;
    endcase
  end

  always_comb begin
    st_wstrb = 8'h00;
    st_wdata = wr_ram_data_i << {off, 3'b000};
    case (funct3_i[1:0])
      2'b00: begin
        st_wstrb = 8'h01 << off;
        st_wdata = {8{wr_ram_data_i[7:0]}};
      end
      2'b01:   st_wstrb = 8'h03 << off;
      2'b10:   st_wstrb = 8'h0F << off;
      default: st_wstrb = 8'hFF;
    endcase
  end

  assign ld_shift = dmem_rdata_i >> {ctx_q.off, 3'b000};

  always_comb begin
    ld_data = ld_shift;
    case (ctx_q.funct3)
      3'b000:  ld_data = {{56{ld_shift[7]}},  ld_shift[7:0]};
      3'b001:  ld_data = {{48{ld_shift[15]}}, ld_shift[15:0]};
      3'b010:  ld_data = {{32{ld_shift[31]}}, ld_shift[31:0]};
      3'b100:  ld_data = {56'd0, ld_shift[7:0]};
      3'b101:  ld_data = {48'd0, ld_shift[15:0]};
      3'b110:  ld_data = {32'd0, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
  end

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int CW = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
  logic [CW-1:0] tmo_cnt_q;

  // Counter sits at zero in IDLE, so it is clear on every entry to WAIT
  always_ff @(posedge clk_i) begin
    if (rst_i || state_q == IDLE) tmo_cnt_q <= '0;
    else if (!dmem_ack_i)         tmo_cnt_q <= tmo_cnt_q + 1'b1;
  end

  assign tmo_expire = (tmo_cnt_q == CW'(TIMEOUT_CYCLES - 1));
`else
  assign tmo_expire = 1'b0;
  assign bus_err_o  = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (valid_i && is_mem && aligned) state_d = WAIT;
      WAIT:    if (dmem_ack_i || tmo_expire)     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= '0;
      dmem_wdata_o <= '0;
      dmem_wstrb_o <= '0;
      valid_o      <= 1'b0;
      reg_write_o  <= 1'b0;
      rd_o         <= '0;
      mem_result_o <= '0;
      misalign_o   <= 1'b0;
      ctx_q        <= '0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      bus_err_o    <= 1'b0;
`endif
    end else begin
      valid_o     <= 1'b0;
      reg_write_o <= 1'b0;
      misalign_o  <= 1'b0;
`ifdef MEM_ACCESS_TIMEOUT_EN
      bus_err_o   <= 1'b0;
`endif
      case (state_q)
        IDLE: begin
          if (valid_i) begin
            if (!is_mem) begin
              valid_o      <= 1'b1;
              reg_write_o  <= reg_write_i && (rd_i != 5'd0);
              rd_o         <= rd_i;
              mem_result_o <= alu_result_i;
            end else if (!aligned) begin
              valid_o    <= 1'b1;
              misalign_o <= 1'b1;
              rd_o       <= rd_i;
            end else begin
              // Write wins when both read and write are flagged
              dmem_req_o     <= 1'b1;
              dmem_we_o      <= mem_write_i;
              dmem_addr_o    <= {alu_result_i[63:3], 3'b000};
              dmem_wdata_o   <= st_wdata;
              dmem_wstrb_o   <= mem_write_i ? st_wstrb : 8'h00;
              ctx_q.is_store  <= mem_write_i;
              ctx_q.reg_write <= reg_write_i;
              ctx_q.rd        <= rd_i;
              ctx_q.funct3    <= funct3_i;
              ctx_q.off       <= off;
            end
          end
        end
        WAIT: begin
          if (dmem_ack_i) begin
            dmem_req_o <= 1'b0;
            valid_o    <= 1'b1;
            rd_o       <= ctx_q.rd;
            if (!ctx_q.is_store) begin
              mem_result_o <= ld_data;
              reg_write_o  <= ctx_q.reg_write && (ctx_q.rd != 5'd0);
            end
          end else if (tmo_expire) begin
            dmem_req_o <= 1'b0;
            valid_o    <= 1'b1;
`ifdef MEM_ACCESS_TIMEOUT_EN
            bus_err_o  <= 1'b1;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected retirements queued at issue, checked when valid_o pulses.
// Define MEM_ACCESS_TIMEOUT_EN to also exercise the watchdog with TIMEOUT_CYCLES=4.
module tb_mem_access_stage;

`ifdef MEM_ACCESS_TIMEOUT_EN
  localparam int TMO = 4;
`else
  localparam int TMO = 255;
`endif

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b0;
  logic        valid_i = 1'b0, mem_read_i = 1'b0, mem_write_i = 1'b0, reg_write_i = 1'b0;
  logic [2:0]  funct3_i = '0;
  logic [4:0]  rd_i = '0;
  logic [63:0] alu_result_i = '0, wr_ram_data_i = '0, dmem_rdata_i = '0;
  logic        dmem_ack_i = 1'b0;
  logic        stall_o, dmem_req_o, dmem_we_o, valid_o, reg_write_o, misalign_o, bus_err_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o, mem_result_o;
  logic [7:0]  dmem_wstrb_o;
  logic [4:0]  rd_o;

  mem_access_stage #(.XLEN(64), .TIMEOUT_CYCLES(TMO)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .mem_read_i(mem_read_i),
    .mem_write_i(mem_write_i), .reg_write_i(reg_write_i), .funct3_i(funct3_i), .rd_i(rd_i),
    .alu_result_i(alu_result_i), .wr_ram_data_i(wr_ram_data_i), .stall_o(stall_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_wstrb_o(dmem_wstrb_o), .dmem_ack_i(dmem_ack_i),
    .dmem_rdata_i(dmem_rdata_i), .valid_o(valid_o), .reg_write_o(reg_write_o), .rd_o(rd_o),
    .mem_result_o(mem_result_o), .misalign_o(misalign_o), .bus_err_o(bus_err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    string       name;
    logic        rw;
    logic [4:0]  rd;
    logic [63:0] res;
    logic        chk_res;
    logic        mis;
    logic        berr;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Retirement monitor: every valid_o pulse must match the oldest queued expectation
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (valid_o === 1'b1) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL unexpected_valid: valid_o=1 rd_o=%0d with no op outstanding", rd_o);
        end else begin
          e = sb.pop_front();
          if (reg_write_o !== e.rw || misalign_o !== e.mis || bus_err_o !== e.berr ||
              (e.chk_res && (mem_result_o !== e.res || rd_o !== e.rd))) begin
            errors++;
            $display("FAIL %s: got rw=%b mis=%b berr=%b rd=%0d res=%h, expected rw=%b mis=%b berr=%b rd=%0d res=%h",
                     e.name, reg_write_o, misalign_o, bus_err_o, rd_o, mem_result_o,
                     e.rw, e.mis, e.berr, e.rd, e.res);
          end
        end
      end
    end
  end

  function automatic logic [63:0] load_model(input logic [63:0] rdata, input logic [2:0] off,
                                             input logic [2:0] f3);
    int          n = 1 << f3[1:0];
    logic [63:0] r = '0;
    for (int i = 0; i < 8; i++)
      if (i < n) r[8*i +: 8] = rdata[8*((int'(off) + i) % 8) +: 8];
    if (!f3[2] && n < 8 && r[8*n-1])
      for (int i = 0; i < 8; i++)
        if (i >= n) r[8*i +: 8] = 8'hFF;
    return r;
  endfunction

  task automatic drive_op(input logic rd_en, input logic wr_en, input logic rw, input logic [2:0] f3,
                          input logic [4:0] rd, input logic [63:0] addr, input logic [63:0] data);
    valid_i = 1'b1; mem_read_i = rd_en; mem_write_i = wr_en; reg_write_i = rw;
    funct3_i = f3; rd_i = rd; alu_result_i = addr; wr_ram_data_i = data;
  endtask

  task automatic idle_inputs();
    valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0; reg_write_i = 1'b0;
  endtask

  task automatic mem_op(input string name, input logic rd_en, input logic wr_en, input logic [2:0] f3,
                        input logic [4:0] rd, input logic [63:0] addr, input logic [63:0] data,
                        input logic [63:0] rdata, input int n_wait);
    exp_t        e;
    logic [7:0]  xs;
    logic [63:0] xd;
    logic [63:0] xa;
    int          stalls;
    logic        hold_ok;
    int          sz;
    sz = int'(f3[1:0]);
    xa = {addr[63:3], 3'b000};
    xs = !wr_en ? 8'h00 : (sz == 0) ? 8'h01 << addr[2:0] : (sz == 1) ? 8'h03 << addr[2:0] :
         (sz == 2) ? 8'h0F << addr[2:0] : 8'hFF;
    xd = (sz == 0) ? {8{data[7:0]}} : data << (8 * addr[2:0]);
    e.name = name; e.rw = !wr_en && (rd != 0); e.rd = rd; e.res = load_model(rdata, addr[2:0], f3);
    e.chk_res = !wr_en; e.mis = 1'b0; e.berr = 1'b0;
    sb.push_back(e);
    drive_op(rd_en, wr_en, 1'b1, f3, rd, addr, data);
    step();
    // Junk non-memory op presented during WAIT must be ignored
    drive_op(1'b0, 1'b0, 1'b1, 3'b000, 5'd9, 64'hDEAD, 64'h0);
    checks++;
    if (dmem_req_o !== 1'b1 || dmem_we_o !== wr_en || dmem_addr_o !== xa || dmem_wstrb_o !== xs ||
        (wr_en && dmem_wdata_o !== xd)) begin
      errors++;
      $display("FAIL %s_req: req=%b we=%b addr=%h strb=%h wdata=%h, expected req=1 we=%b addr=%h strb=%h wdata=%h",
               name, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wstrb_o, dmem_wdata_o, wr_en, xa, xs, xd);
    end
    stalls = 0;
    hold_ok = 1'b1;
    for (int k = 0; k < n_wait; k++) begin
      if (stall_o === 1'b1) stalls++;
      if (dmem_req_o !== 1'b1 || dmem_addr_o !== xa || dmem_wstrb_o !== xs) hold_ok = 1'b0;
      if (k == n_wait - 1) begin
        dmem_ack_i = 1'b1;
        dmem_rdata_i = rdata;
      end
      step();
    end
    dmem_ack_i = 1'b0;
    idle_inputs();
    checks++;
    if (stalls != n_wait || !hold_ok || stall_o !== 1'b0 || dmem_req_o !== 1'b0) begin
      errors++;
      $display("FAIL %s_done: stall_cycles=%0d hold_ok=%b stall=%b req=%b, expected stall_cycles=%0d hold_ok=1 stall=0 req=0",
               name, stalls, hold_ok, stall_o, dmem_req_o, n_wait);
    end
  endtask

  task automatic alu_op(input string name, input logic rw, input logic [4:0] rd, input logic [63:0] val);
    exp_t e;
    e.name = name; e.rw = rw && (rd != 0); e.rd = rd; e.res = val;
    e.chk_res = 1'b1; e.mis = 1'b0; e.berr = 1'b0;
    sb.push_back(e);
    drive_op(1'b0, 1'b0, rw, 3'b000, rd, val, 64'h0);
    step();
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    step(); step();
    rst_i = 1'b0;
    checks++;
    if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o, valid_o,
         reg_write_o, rd_o, mem_result_o, misalign_o, bus_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_outputs: stall=%b req=%b valid=%b res=%h addr=%h, expected all 0",
               stall_o, dmem_req_o, valid_o, mem_result_o, dmem_addr_o);
    end
    drive_op(1'b1, 1'b0, 1'b1, 3'b011, 5'd4, 64'h40, 64'h0);
    step();
    idle_inputs();
    checks++;
    if (dmem_req_o !== 1'b1 || stall_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_pre_req: req=%b stall=%b, expected req=1 stall=1", dmem_req_o, stall_o);
    end
    rst_i = 1'b1;
    step();
    rst_i = 1'b0;
    checks++;
    if ({stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o, valid_o,
         reg_write_o, rd_o, mem_result_o, misalign_o, bus_err_o} !== '0) begin
      errors++;
      $display("FAIL reset_mid_access: req=%b stall=%b addr=%h, expected all 0", dmem_req_o, stall_o, dmem_addr_o);
    end
    step();
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'hFFFF;
    step();
    dmem_ack_i = 1'b0;
    step();
    checks++;
    if (valid_o !== 1'b0 || stall_o !== 1'b0) begin
      errors++;
      $display("FAIL stray_ack: valid=%b stall=%b, expected valid=0 stall=0", valid_o, stall_o);
    end
  endtask

  task automatic test_alu();
    alu_op("alu_rd5", 1'b1, 5'd5, 64'h1234);
    alu_op("alu_rd0", 1'b1, 5'd0, 64'h1234);
    idle_inputs();
    step();
  endtask

  task automatic test_load();
    mem_op("lb_1003", 1'b1, 1'b0, 3'b000, 5'd10, 64'h1003, 64'h0, 64'h00000000_80000000, 3);
    checks++;
    if (mem_result_o !== 64'hFFFF_FFFF_FFFF_FF80) begin
      errors++;
      $display("FAIL lb_const: res=%h, expected ffffffffffffff80", mem_result_o);
    end
    mem_op("lbu_1003", 1'b1, 1'b0, 3'b100, 5'd11, 64'h1003, 64'h0, 64'h00000000_80000000, 3);
    checks++;
    if (mem_result_o !== 64'h80) begin
      errors++;
      $display("FAIL lbu_const: res=%h, expected 80", mem_result_o);
    end
  endtask

  task automatic test_store();
    mem_op("sh_2006", 1'b0, 1'b1, 3'b001, 5'd3, 64'h2006, 64'hBEEF, 64'h0, 1);
    mem_op("sd_rw_both", 1'b1, 1'b1, 3'b011, 5'd6, 64'h2008, 64'h0123_4567_89AB_CDEF, 64'h55, 2);
  endtask

  task automatic test_misalign();
    exp_t e;
    e.name = "lw_3002"; e.rw = 1'b0; e.rd = 5'd7; e.res = '0; e.chk_res = 1'b0; e.mis = 1'b1; e.berr = 1'b0;
    sb.push_back(e);
    drive_op(1'b1, 1'b0, 1'b1, 3'b010, 5'd7, 64'h3002, 64'h0);
    step();
    idle_inputs();
    checks++;
    if (dmem_req_o !== 1'b0 || stall_o !== 1'b0 || valid_o !== 1'b1) begin
      errors++;
      $display("FAIL misalign_noreq: req=%b stall=%b valid=%b, expected req=0 stall=0 valid=1",
               dmem_req_o, stall_o, valid_o);
    end
    step();
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 4; i++) begin
      alu_op("b2b_alu", 1'b1, 5'(i + 1), 64'hA000 + 64'(i));
      checks++;
      if (stall_o !== 1'b0) begin
        errors++;
        $display("FAIL b2b_stall: stall=%b, expected 0", stall_o);
      end
    end
    idle_inputs();
    step(); step();
    checks++;
    if (mem_result_o !== 64'hA003 || valid_o !== 1'b0 || reg_write_o !== 1'b0) begin
      errors++;
      $display("FAIL idle_hold: res=%h valid=%b rw=%b, expected res=a003 valid=0 rw=0",
               mem_result_o, valid_o, reg_write_o);
    end
  endtask

  task automatic test_random();
    logic [2:0]  f3;
    logic        st, rd_en;
    logic [63:0] addr;
    int          n;
    for (int i = 0; i < 12; i++) begin
      f3 = 3'($urandom_range(0, 7));
      st = 1'($urandom_range(0, 1));
      rd_en = st ? 1'($urandom_range(0, 1)) : 1'b1;
      n = 1 << f3[1:0];
      addr = {$urandom, $urandom};
      addr[2:0] = 3'($urandom_range(0, 7)) & ~3'(n - 1);
      mem_op(st ? "rand_store" : "rand_load", rd_en, st, f3, 5'($urandom_range(0, 31)), addr,
             {$urandom, $urandom}, {$urandom, $urandom}, $urandom_range(1, 3));
    end
  endtask

`ifdef MEM_ACCESS_TIMEOUT_EN
  task automatic test_timeout();
    exp_t e;
    int   req_cycles;
    e.name = "timeout"; e.rw = 1'b0; e.rd = 5'd7; e.res = '0; e.chk_res = 1'b0; e.mis = 1'b0; e.berr = 1'b1;
    sb.push_back(e);
    drive_op(1'b1, 1'b0, 1'b1, 3'b011, 5'd7, 64'h80, 64'h0);
    step();
    idle_inputs();
    req_cycles = 0;
    for (int k = 0; k < 20 && dmem_req_o === 1'b1; k++) begin
      req_cycles++;
      step();
    end
    checks++;
    if (req_cycles != TMO || dmem_req_o !== 1'b0 || bus_err_o !== 1'b1) begin
      errors++;
      $display("FAIL timeout_expiry: req_cycles=%0d req=%b berr=%b, expected req_cycles=%0d req=0 berr=1",
               req_cycles, dmem_req_o, bus_err_o, TMO);
    end
    step();
    mem_op("ack_on_expiry", 1'b1, 1'b0, 3'b010, 5'd8, 64'h88, 64'h0, 64'h0000_0000_8000_0001, TMO);
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misalign();
    test_back_to_back();
    test_random();
`ifdef MEM_ACCESS_TIMEOUT_EN
    test_timeout();
`endif
    for (int k = 0; k < 10 && sb.size() != 0; k++) step();
    step();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d retirements outstanding, expected 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access pipeline stage, directly downstream of the execute stage.
- Consumes the ALU result (address or pass-through value), store data, rd and control from execute.
- Drives a req/ack data-memory bus, performing byte/half/word/dword loads (sign or zero extended) and stores (byte strobes).
- Presents a registered result to write-back; stalls upstream while a bus access is outstanding.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- TIMEOUT_CYCLES, 255, bus watchdog limit; used only with the optional feature.

Ports:
- clk_i  in  1  clock; all state updates on posedge
- rst_i  in  1  synchronous, active-high reset
- valid_i  in  1  execute presents an op this cycle
- mem_read_i  in  1  op is a load
- mem_write_i  in  1  op is a store
- reg_write_i  in  1  op writes rd
- funct3_i  in  3  access size/sign (RV64 load/store encoding)
- rd_i  in  5  destination register
- alu_result_i  in  64  effective address, or the result for non-memory ops
- wr_ram_data_i  in  64  store data; forwarded value from execute
- stall_o  out  1  upstream must hold its inputs
- dmem_req_o  out  1  bus request; held until ack
- dmem_we_o  out  1  1 = write
- dmem_addr_o  out  64  dword-aligned address {addr[63:3],3'b0}
- dmem_wdata_o  out  64  store data shifted to the addressed byte lanes
- dmem_wstrb_o  out  8  byte enables
- dmem_ack_i  in  1  single-cycle completion; rdata valid with ack
- dmem_rdata_i  in  64  read dword
- valid_o  out  1  one-cycle pulse per retired op
- reg_write_o  out  1  write-back enable
- rd_o  out  5  destination register
- mem_result_o  out  64  load data or pass-through ALU result
- misalign_o  out  1  one-cycle pulse: misaligned access dropped
- bus_err_o  out  1  one-cycle pulse: bus timeout (optional feature)

Behaviour:
- Reset:
  - state=IDLE.
  - All outputs 0: stall_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_wdata_o, dmem_wstrb_o, valid_o, reg_write_o, rd_o, mem_result_o, misalign_o, bus_err_o.
  - Reset mid-access drops dmem_req_o the next cycle. An ack arriving in IDLE is ignored.
- FSM states: IDLE, WAIT. stall_o = (state==WAIT), driven combinationally.
- IDLE, valid_i=0:
  - next cycle valid_o=0, reg_write_o=0.
  - Other output registers hold their values.
- IDLE, valid_i=1, non-memory op:
  - next cycle valid_o=1, mem_result_o=alu_result_i, rd_o=rd_i.
  - reg_write_o = reg_write_i & (rd_i!=0).
  - Latency 1 cycle.
- IDLE, valid_i=1, memory op, aligned:
  - Register dmem_req_o=1, dmem_we_o=mem_write_i, address, wdata and wstrb; go to WAIT.
  - If mem_read_i and mem_write_i are both set, the op is treated as a store.
- Alignment rule, by size:
  - half: addr[0]=0
  - word: addr[1:0]=0
  - dword: addr[2:0]=0
  - byte: always aligned
- Misaligned access:
  - No bus request.
  - Next cycle valid_o=1, reg_write_o=0, misalign_o=1 for one cycle.
- Store lanes (off = addr[2:0]):
  - SB (000): wstrb=8'h01<<off, wdata=data[7:0] replicated.
  - SH (001): wstrb=8'h03<<off.
  - SW (010): wstrb=8'h0F<<off.
  - SD (011): wstrb=8'hFF.
  - wdata = data<<(8*off).
  - funct3 1xx on a store is treated as 0xx.
- Loads: wstrb=0. Extract rdata>>(8*off), then extend:
  - LB 000 sign, LH 001 sign, LW 010 sign, LD 011
  - LBU 100 zero, LHU 101 zero, LWU 110 zero
  - 111 treated as LD
- WAIT state:
  - Hold req, we, addr, wdata and wstrb stable; inputs are ignored.
  - On dmem_ack_i: next cycle dmem_req_o=0, valid_o=1, rd_o=captured rd, state=IDLE.
  - Load completion: mem_result_o=extended data, reg_write_o = captured reg_write & rd!=0.
  - Store completion: reg_write_o=0, mem_result_o holds.
- Throughput:
  - Non-memory ops: 1 per cycle.
  - Memory ops: 1 + ack-wait cycles. The next op is accepted in the cycle after ack (stall_o still high during the ack cycle).

Optional Feature:
- Macro: MEM_ACCESS_TIMEOUT_EN.
- Defined:
  - An 8+ bit counter clears on entry to WAIT and increments each WAIT cycle without ack.
  - When it reaches TIMEOUT_CYCLES: drop req, valid_o=1, reg_write_o=0, bus_err_o=1 for one cycle, state=IDLE.
  - Ack on the expiry cycle wins: normal completion, no error.
- Not defined: WAIT persists indefinitely; bus_err_o tied 0.

Test Plan:
- Reset with rst_i=1 while in WAIT with req=1 -> next cycle req=0, stall_o=0, all outputs 0; an ack pulse 2 cycles later produces no valid_o.
- Non-memory op: alu_result=64'h1234, rd=5, reg_write=1 -> next cycle valid_o=1, mem_result_o=64'h1234, rd_o=5, reg_write_o=1. Same op with rd=0 -> reg_write_o=0.
- LB at addr 64'h1003, rdata=64'h00000000_80000000, ack after 3 cycles:
  - dmem_addr_o=64'h1000.
  - stall_o high 3 cycles.
  - Result FFFF_FFFF_FFFF_FF80 with valid_o=1.
  - Same access as LBU -> 64'h80.
- SH at addr 64'h2006, data=64'hBEEF, ack immediate -> wstrb=8'hC0, wdata[63:48]=16'hBEEF, we=1; completion gives valid_o=1, reg_write_o=0.
- LW at addr 64'h3002 -> no req, misalign_o=1 and valid_o=1 next cycle, reg_write_o=0.
- MEM_ACCESS_TIMEOUT_EN with TIMEOUT_CYCLES=4, no ack -> req drops after 4 WAIT cycles, bus_err_o pulses; ack on cycle 4 -> normal completion, bus_err_o=0.
